color_box_tracker: RTL and testbench

- Upstream neighbour of the frame processing stage. Consumes the 49-bit pixel pack.
- Classifies each active pixel against a programmable RGB window and accumulates the bounding box of matching pixels over one frame.
- At frame end, publishes start_x/start_y/end_x/end_y in the packed coordinate format that draw_window consumes.
- Adds a minimum-pixel qualification and a miss-hold so the drawn box does not flicker.

---
 rtl/tracker_pkg.sv | 37 +++
 rtl/rgb_window_match.sv | 56 +++++
 rtl/color_box_tracker.sv | 183 ++++++++++++++++++
 tb/tb_color_box_tracker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared field positions, widths and FSM state for the colour box tracker
package tracker_pkg;

  localparam int PACK_W    = 49;
  localparam int PCLK_BIT  = 48;
  localparam int HS_BIT    = 47;
  localparam int VS_BIT    = 46;
  localparam int DE_BIT    = 45;
  localparam int R_HI      = 44;
  localparam int R_LO      = 37;
  localparam int G_HI      = 36;
  localparam int G_LO      = 29;
  localparam int B_HI      = 28;
  localparam int B_LO      = 21;
  localparam int X_HI      = 20;
  localparam int X_LO      = 10;
  localparam int Y_HI      = 9;
  localparam int Y_LO      = 0;
  localparam int PACK_XW   = X_HI - X_LO + 1;
  localparam int PACK_YW   = Y_HI - Y_LO + 1;

  localparam int PIX_CNT_W = 20;
  localparam int MISS_W    = 8;

  typedef enum logic [1:0] {
    WAIT_VS,
    ACCUM,
    COMMIT
  } tracker_state_t;

  // Inclusive window test; lo > hi can never be satisfied, so that channel never matches.
  function automatic logic in_window(input logic [7:0] v, input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rgb_window_match.sv
// rtl/rgb_window_match.sv - first pipeline stage: registered RGB window match with x, y and vs
module rgb_window_match
  import tracker_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PACK_W-1:0] i_pack,
  input  logic [7:0]        r_min,
  input  logic [7:0]        r_max,
  input  logic [7:0]        g_min,
  input  logic [7:0]        g_max,
  input  logic [7:0]        b_min,
  input  logic [7:0]        b_max,
  output logic              s1_match,
  output logic [XW-1:0]     s1_x,
  output logic [YW-1:0]     s1_y,
  output logic              s1_vs
);

  logic [7:0]         pix_r;
  logic [7:0]         pix_g;
  logic [7:0]         pix_b;
  logic [PACK_XW-1:0] pix_x;
  logic [PACK_YW-1:0] pix_y;
  logic               unused_pack_bits;

  assign pix_r = i_pack[R_HI:R_LO];
  assign pix_g = i_pack[G_HI:G_LO];
  assign pix_b = i_pack[B_HI:B_LO];
  assign pix_x = i_pack[X_HI:X_LO];
  assign pix_y = i_pack[Y_HI:Y_LO];

  // pclk copy and hs carry no information here; coordinates above the frame size are never produced.
  assign unused_pack_bits = ^{i_pack[PCLK_BIT], i_pack[HS_BIT], pix_x, pix_y};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_match <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_vs    <= 1'b0;
    end else begin
      s1_match <= i_pack[DE_BIT]
                & in_window(pix_r, r_min, r_max)
                & in_window(pix_g, g_min, g_max)
                & in_window(pix_b, b_min, b_max);
      s1_x     <= pix_x[XW-1:0];
      s1_y     <= pix_y[YW-1:0];
      s1_vs    <= i_pack[VS_BIT];
    end
  end

endmodule

// File: rtl/color_box_tracker.sv
// rtl/color_box_tracker.sv - per-frame bounding box of pixels inside an RGB window, with min-count and miss-hold
module color_box_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int MIN_PIXELS  = 64,
  parameter int MISS_FRAMES = 4,
  localparam int XW         = $clog2(H_ACT),
  localparam int YW         = $clog2(V_ACT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PACK_W-1:0]    i_pack,
  input  logic [7:0]           r_min,
  input  logic [7:0]           r_max,
  input  logic [7:0]           g_min,
  input  logic [7:0]           g_max,
  input  logic [7:0]           b_min,
  input  logic [7:0]           b_max,
  output logic [XW-1:0]        start_x,
  output logic [YW-1:0]        start_y,
  output logic [XW-1:0]        end_x,
  output logic [YW-1:0]        end_y,
  output logic                 box_valid,
  output logic [PIX_CNT_W-1:0] pix_count,
  output logic                 frame_done
);

  localparam logic [XW-1:0]        X_LAST     = XW'(H_ACT - 1);
  localparam logic [YW-1:0]        Y_LAST     = YW'(V_ACT - 1);
  localparam logic [PIX_CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [PIX_CNT_W-1:0] MIN_CNT    = PIX_CNT_W'(MIN_PIXELS);
  localparam logic [MISS_W-1:0]    MISS_LIMIT = MISS_W'(MISS_FRAMES);
  localparam logic [MISS_W-1:0]    MISS_MAX   = '1;

  logic                 s1_match;
  logic [XW-1:0]        s1_x;
  logic [YW-1:0]        s1_y;
  logic                 s1_vs;

  logic                 vs_s2;
  logic                 vs_s2_d;
  logic                 vs_rise;

  logic [XW-1:0]        min_x;
  logic [XW-1:0]        max_x;
  logic [YW-1:0]        min_y;
  logic [YW-1:0]        max_y;
  logic [PIX_CNT_W-1:0] cnt;
  logic [MISS_W-1:0]    miss_cnt;
  logic [MISS_W-1:0]    miss_nxt;

  tracker_state_t       state;
  tracker_state_t       state_nxt;
  logic                 acc_clear;
  logic                 acc_en;
  logic                 do_commit;

  rgb_window_match #(
    .XW (XW),
    .YW (YW)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .i_pack   (i_pack),
    .r_min    (r_min),
    .r_max    (r_max),
    .g_min    (g_min),
    .g_max    (g_max),
    .b_min    (b_min),
    .b_max    (b_max),
    .s1_match (s1_match),
    .s1_x     (s1_x),
    .s1_y     (s1_y),
    .s1_vs    (s1_vs)
  );

  // vs delayed to the accumulator stage, so the frame's last pixel lands before the edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s2   <= 1'b0;
      vs_s2_d <= 1'b0;
    end else begin
      vs_s2   <= s1_vs;
      vs_s2_d <= vs_s2;
    end
  end

  assign vs_rise  = vs_s2 & ~vs_s2_d;
  assign miss_nxt = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MISS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_VS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    do_commit = 1'b0;
    case (state)
      WAIT_VS: begin
        if (vs_rise) begin
          acc_clear = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (vs_rise) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        acc_clear = 1'b1;
        state_nxt = ACCUM;
      end
      default: begin
        state_nxt = WAIT_VS;
      end
    endcase
  end

  // Clearing wins over a same-cycle match; such a pixel can only arrive during vs.
  always_ff @(posedge clk) begin
    if (rst || acc_clear) begin
      min_x <= X_LAST;
      min_y <= Y_LAST;
      max_x <= '0;
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_en && s1_match) begin
      if (s1_x < min_x) min_x <= s1_x;
      if (s1_y < min_y) min_y <= s1_y;
      if (s1_x > max_x) max_x <= s1_x;
      if (s1_y > max_y) max_y <= s1_y;
      if (cnt != CNT_MAX) cnt <= cnt + PIX_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_x    <= '0;
      start_y    <= '0;
      end_x      <= '0;
      end_y      <= '0;
      box_valid  <= 1'b0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      frame_done <= do_commit;
      if (do_commit) begin
        pix_count <= cnt;
        if (cnt >= MIN_CNT) begin
          start_x   <= min_x;
          start_y   <= min_y;
          end_x     <= max_x;
          end_y     <= max_y;
          box_valid <= 1'b1;
          miss_cnt  <= '0;
        end else begin
          miss_cnt <= miss_nxt;
          // Drop the box only on the exact miss that reaches the limit; later misses keep it cleared.
          if (miss_nxt == MISS_LIMIT) begin
            start_x   <= '0;
            start_y   <= '0;
            end_x     <= '0;
            end_y     <= '0;
            box_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_color_box_tracker.sv
// tb/tb_color_box_tracker.sv - scoreboard bench for color_box_tracker with two qualification settings
module tb_color_box_tracker;

  localparam int H      = 16;
  localparam int V      = 8;
  localparam int XW     = 4;
  localparam int YW     = 3;
  localparam int MISS_F = 2;

  typedef struct {
    int sx;
    int sy;
    int ex;
    int ey;
    int valid;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [48:0] i_pack = '0;
  logic [7:0]  r_min, r_max, g_min, g_max, b_min, b_max;

  logic [XW-1:0] sx [2];
  logic [XW-1:0] ex [2];
  logic [YW-1:0] sy [2];
  logic [YW-1:0] ey [2];
  logic          bv [2];
  logic [19:0]   pc [2];
  logic          fd [2];

  int   vectors = 0;
  int   errors  = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  int min_px [2] = '{4, 1};
  int armed;
  int acnt, amin_x, amin_y, amax_x, amax_y;
  int miss [2];
  int bsx [2], bsy [2], bex [2], bey [2], bval [2];

  always #5 clk = ~clk;

  color_box_tracker #(.H_ACT(H), .V_ACT(V), .MIN_PIXELS(4), .MISS_FRAMES(MISS_F)) dut_a (
    .clk(clk), .rst(rst), .i_pack(i_pack),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max), .b_min(b_min), .b_max(b_max),
    .start_x(sx[0]), .start_y(sy[0]), .end_x(ex[0]), .end_y(ey[0]),
    .box_valid(bv[0]), .pix_count(pc[0]), .frame_done(fd[0])
  );

  color_box_tracker #(.H_ACT(H), .V_ACT(V), .MIN_PIXELS(1), .MISS_FRAMES(MISS_F)) dut_b (
    .clk(clk), .rst(rst), .i_pack(i_pack),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max), .b_min(b_min), .b_max(b_max),
    .start_x(sx[1]), .start_y(sy[1]), .end_x(ex[1]), .end_y(ey[1]),
    .box_valid(bv[1]), .pix_count(pc[1]), .frame_done(fd[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference model: a frame is everything between two vs rises; the first rise after reset only arms.
  task automatic model_clear_acc();
    acnt = 0; amin_x = H; amin_y = V; amax_x = -1; amax_y = -1;
  endtask

  task automatic model_reset();
    armed = 0;
    model_clear_acc();
    for (int k = 0; k < 2; k++) begin
      miss[k] = 0; bsx[k] = 0; bsy[k] = 0; bex[k] = 0; bey[k] = 0; bval[k] = 0;
    end
  endtask

  task automatic model_vs();
    exp_t e;
    if (armed != 0) begin
      for (int k = 0; k < 2; k++) begin
        if (acnt >= min_px[k]) begin
          bsx[k] = amin_x; bsy[k] = amin_y; bex[k] = amax_x; bey[k] = amax_y;
          bval[k] = 1; miss[k] = 0;
        end else begin
          if (miss[k] < 255) miss[k]++;
          if (miss[k] == MISS_F) begin
            bsx[k] = 0; bsy[k] = 0; bex[k] = 0; bey[k] = 0; bval[k] = 0;
          end
        end
        e.sx = bsx[k]; e.sy = bsy[k]; e.ex = bex[k]; e.ey = bey[k];
        e.valid = bval[k]; e.cnt = acnt;
        if (k == 0) q_a.push_back(e);
        else q_b.push_back(e);
      end
    end
    armed = 1;
    model_clear_acc();
  endtask

  task automatic drive_pixel(input int x, input int y, input logic de,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge clk); #1;
    i_pack = {1'b0, 1'b0, 1'b0, de, r, g, b, 11'(x), 10'(y)};
    if (de && r >= r_min && r <= r_max && g >= g_min && g <= g_max && b >= b_min && b <= b_max) begin
      acnt++;
      if (x < amin_x) amin_x = x;
      if (y < amin_y) amin_y = y;
      if (x > amax_x) amax_x = x;
      if (y > amax_y) amax_y = y;
    end
  endtask

  task automatic vs_pulse();
    @(posedge clk); #1;
    i_pack = {1'b0, 1'b0, 1'b1, 1'b0, 45'd0};
    model_vs();
    repeat (3) @(posedge clk);
    #1;
    i_pack = '0;
    repeat (7) @(posedge clk);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] lo, input logic [7:0] hi, input int dens);
    if (lo <= hi && int'($urandom_range(0, 9)) < dens * 3)
      return 8'($urandom_range(int'(hi), int'(lo)));
    return 8'($urandom);
  endfunction

  task automatic frame_rows(input int pat, input int y0, input int y1);
    int dens;
    dens = $urandom_range(0, 3);
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < H; x++) begin
        logic [7:0] r, g, b;
        logic de;
        de = 1'b1; r = 8'd0; g = 8'd0; b = 8'd0;
        case (pat)
          0: if (x >= 3 && x <= 6 && y >= 2 && y <= 4) begin r = 8'd240; g = 8'd10; b = 8'd20; end
          1: if (y == 2 && x >= 3 && x <= 5) begin r = 8'd230; g = 8'd0; b = 8'd50; end
          2: if (x == H - 1 && y == V - 1) begin r = 8'd255; g = 8'd0; b = 8'd0; end
          3: begin r = 8'd200; g = 8'd25; b = 8'd5; end
          default: begin
            de = ($urandom_range(0, 7) != 0);
            r = pick(r_min, r_max, dens);
            g = pick(g_min, g_max, dens);
            b = pick(b_min, b_max, dens);
          end
        endcase
        drive_pixel(x, y, de, r, g, b);
      end
    end
  endtask

  task automatic frame(input int pat);
    frame_rows(pat, 0, V - 1);
    vs_pulse();
  endtask

  task automatic set_window(input logic [7:0] rl, input logic [7:0] rh, input logic [7:0] gl,
                            input logic [7:0] gh, input logic [7:0] bl, input logic [7:0] bh);
    r_min = rl; r_max = rh; g_min = gl; g_max = gh; b_min = bl; b_max = bh;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d reset start_x", k), 32'(sx[k]), 0);
      check($sformatf("dut%0d reset start_y", k), 32'(sy[k]), 0);
      check($sformatf("dut%0d reset end_x", k), 32'(ex[k]), 0);
      check($sformatf("dut%0d reset end_y", k), 32'(ey[k]), 0);
      check($sformatf("dut%0d reset box_valid", k), 32'(bv[k]), 0);
      check($sformatf("dut%0d reset pix_count", k), 32'(pc[k]), 0);
      check($sformatf("dut%0d reset frame_done", k), 32'(fd[k]), 0);
    end
    rst = 1'b0;
  endtask

  task automatic mon_check(input int k);
    exp_t e;
    int n;
    n = (k == 0) ? q_a.size() : q_b.size();
    if (n == 0) begin
      vectors++;
      errors++;
      $display("FAIL dut%0d unexpected_frame_done: got pulse, expected none", k);
      return;
    end
    if (k == 0) e = q_a.pop_front();
    else e = q_b.pop_front();
    check($sformatf("dut%0d pix_count", k), 32'(pc[k]), e.cnt);
    check($sformatf("dut%0d box_valid", k), 32'(bv[k]), e.valid);
    check($sformatf("dut%0d start_x", k), 32'(sx[k]), e.sx);
    check($sformatf("dut%0d start_y", k), 32'(sy[k]), e.sy);
    check($sformatf("dut%0d end_x", k), 32'(ex[k]), e.ex);
    check($sformatf("dut%0d end_y", k), 32'(ey[k]), e.ey);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst === 1'b0 && fd[k] === 1'b1) mon_check(k);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within 1000000 time units");
    $fatal(1);
  end

  initial begin
    set_window(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
    model_reset();
    do_reset(3);

    frame(0);
    frame(0);
    frame(1);
    frame(1);
    frame(2);

    set_window(8'd100, 8'd50, 8'd0, 8'd50, 8'd0, 8'd50);
    frame(3);
    set_window(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
    frame(3);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] rl, gl, bl;
      rl = 8'($urandom_range(0, 160));
      gl = 8'($urandom_range(0, 160));
      bl = 8'($urandom_range(0, 160));
      if ($urandom_range(0, 7) == 0)
        set_window(rl + 8'd40, rl, gl, gl + 8'd90, bl, bl + 8'd90);
      else
        set_window(rl, rl + 8'($urandom_range(20, 95)), gl, gl + 8'($urandom_range(20, 95)),
                   bl, bl + 8'($urandom_range(20, 95)));
      frame(4);
    end

    set_window(8'd200, 8'd255, 8'd0, 8'd50, 8'd0, 8'd50);
    frame(0);
    frame_rows(0, 0, 3);
    do_reset(1);
    frame_rows(0, 4, V - 1);
    vs_pulse();
    frame(0);
    frame(2);

    repeat (20) @(posedge clk);
    #1;
    check("pending dut0 frame_done", 32'(q_a.size()), 0);
    check("pending dut1 frame_done", 32'(q_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
